// File: rtl/dp_defs.sv
// Shared data-processing definitions: opcode and condition encodings, NZCV bit positions.
package dp_defs;

    localparam int unsigned DATA_W = 32;

    localparam logic [3:0] OP_AND = 4'h0;
    localparam logic [3:0] OP_EOR = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_RSB = 4'h3;
    localparam logic [3:0] OP_ADD = 4'h4;
    localparam logic [3:0] OP_ADC = 4'h5;
    localparam logic [3:0] OP_SBC = 4'h6;
    localparam logic [3:0] OP_RSC = 4'h7;
    localparam logic [3:0] OP_TST = 4'h8;
    localparam logic [3:0] OP_TEQ = 4'h9;
    localparam logic [3:0] OP_CMP = 4'hA;
    localparam logic [3:0] OP_CMN = 4'hB;
    localparam logic [3:0] OP_ORR = 4'hC;
    localparam logic [3:0] OP_MOV = 4'hD;
    localparam logic [3:0] OP_BIC = 4'hE;
    localparam logic [3:0] OP_MVN = 4'hF;

    localparam logic [3:0] COND_EQ = 4'h0;
    localparam logic [3:0] COND_NE = 4'h1;
    localparam logic [3:0] COND_CS = 4'h2;
    localparam logic [3:0] COND_CC = 4'h3;
    localparam logic [3:0] COND_MI = 4'h4;
    localparam logic [3:0] COND_PL = 4'h5;
    localparam logic [3:0] COND_VS = 4'h6;
    localparam logic [3:0] COND_VC = 4'h7;
    localparam logic [3:0] COND_HI = 4'h8;
    localparam logic [3:0] COND_LS = 4'h9;
    localparam logic [3:0] COND_GE = 4'hA;
    localparam logic [3:0] COND_LT = 4'hB;
    localparam logic [3:0] COND_GT = 4'hC;
    localparam logic [3:0] COND_LE = 4'hD;
    localparam logic [3:0] COND_AL = 4'hE;
    localparam logic [3:0] COND_NV = 4'hF;

    localparam int unsigned FLAG_N = 3;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_V = 0;

endpackage

// File: rtl/condition_evaluator.sv
// Combinational evaluation of a 4-bit condition field against NZCV; shared with the branch unit.
module condition_evaluator
    import dp_defs::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       pass
);

    logic n, z, c, v;

    always_comb begin
        n    = flags[FLAG_N];
        z    = flags[FLAG_Z];
        c    = flags[FLAG_C];
        v    = flags[FLAG_V];
        pass = 1'b0;
        case (cond)
            COND_EQ: pass = z;
            COND_NE: pass = ~z;
            COND_CS: pass = c;
            COND_CC: pass = ~c;
            COND_MI: pass = n;
            COND_PL: pass = ~n;
            COND_VS: pass = v;
            COND_VC: pass = ~v;
            COND_HI: pass = c & ~z;
            COND_LS: pass = ~c | z;
            COND_GE: pass = (n == v);
            COND_LT: pass = (n != v);
            COND_GT: pass = ~z & (n == v);
            COND_LE: pass = z | (n != v);
            COND_AL: pass = 1'b1;
            default: pass = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_status_unit.sv
// Execute-stage ALU with the NZCV status register and condition check of the instruction in execute.
module alu_status_unit
    import dp_defs::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [3:0]        opcode,
    input  logic              s_bit,
    input  logic [3:0]        cond,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              shifter_carry,
    input  logic              stall,
    output logic [DATA_W-1:0] result,
    output logic              rd_write,
    output logic              cond_pass,
    output logic [3:0]        flags
);

    logic [3:0]        flags_q, flags_d;
    logic [DATA_W-1:0] op_x, op_y;
    logic              carry_in;
    logic              is_arith;
    logic              is_compare;
    logic              flag_we;
    logic [DATA_W:0]   sum;
    logic              overflow;

    condition_evaluator u_cond (
        .cond  (cond),
        .flags (flags_q),
        .pass  (cond_pass)
    );

    // Adder operand steering: subtraction is x + ~y + cin, reverse forms swap the operands.
    always_comb begin
        op_x     = a;
        op_y     = b;
        carry_in = 1'b0;
        is_arith = 1'b1;
        case (opcode)
            OP_SUB, OP_CMP: begin op_y = ~b; carry_in = 1'b1; end
            OP_RSB:         begin op_x = b; op_y = ~a; carry_in = 1'b1; end
            OP_ADD, OP_CMN: begin carry_in = 1'b0; end
            OP_ADC:         begin carry_in = flags_q[FLAG_C]; end
            OP_SBC:         begin op_y = ~b; carry_in = flags_q[FLAG_C]; end
            OP_RSC:         begin op_x = b; op_y = ~a; carry_in = flags_q[FLAG_C]; end
            default:        is_arith = 1'b0;
        endcase
    end

    assign sum      = {1'b0, op_x} + {1'b0, op_y} + (DATA_W+1)'(carry_in);
    assign overflow = (op_x[DATA_W-1] == op_y[DATA_W-1]) && (sum[DATA_W-1] != op_x[DATA_W-1]);

    always_comb begin
        result = sum[DATA_W-1:0];
        case (opcode)
            OP_AND, OP_TST: result = a & b;
            OP_EOR, OP_TEQ: result = a ^ b;
            OP_ORR:         result = a | b;
            OP_MOV:         result = b;
            OP_BIC:         result = a & ~b;
            OP_MVN:         result = ~b;
            default:        result = sum[DATA_W-1:0];
        endcase
    end

    assign is_compare = (opcode[3:2] == 2'b10);
    assign rd_write   = cond_pass & ~is_compare;
    assign flag_we    = cond_pass & ~stall & (s_bit | is_compare);

    // Logical ops take C from the shifter and leave V alone.
    always_comb begin
        flags_d = flags_q;
        if (flag_we) begin
            flags_d[FLAG_N] = result[DATA_W-1];
            flags_d[FLAG_Z] = (result == '0);
            flags_d[FLAG_C] = is_arith ? sum[DATA_W] : shifter_carry;
            flags_d[FLAG_V] = is_arith ? overflow : flags_q[FLAG_V];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) flags_q <= 4'b0000;
        else       flags_q <= flags_d;
    end

    assign flags = flags_q;

endmodule

// File: tb/tb_alu_status_unit.sv
// Directed self-checking bench for alu_status_unit.
module tb_alu_status_unit;
    import dp_defs::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  opcode;
    logic        s_bit;
    logic [3:0]  cond;
    logic [31:0] a, b;
    logic        shifter_carry;
    logic        stall;
    logic [31:0] result;
    logic        rd_write;
    logic        cond_pass;
    logic [3:0]  flags;

    int compared   = 0;
    int mismatched = 0;

    alu_status_unit dut (
        .clk           (clk),
        .reset         (reset),
        .opcode        (opcode),
        .s_bit         (s_bit),
        .cond          (cond),
        .a             (a),
        .b             (b),
        .shifter_carry (shifter_carry),
        .stall         (stall),
        .result        (result),
        .rd_write      (rd_write),
        .cond_pass     (cond_pass),
        .flags         (flags)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [3:0] op, input logic s, input logic [3:0] cnd,
                         input logic [31:0] aa, input logic [31:0] bb,
                         input logic sc, input logic st);
        opcode = op; s_bit = s; cond = cnd; a = aa; b = bb;
        shifter_carry = sc; stall = st;
        #1;
    endtask

    task automatic next_edge();
        @(posedge clk);
        #1;
    endtask

    logic [3:0]  ops  [12];
    logic [31:0] exps [12];
    logic [15:0] pass_tbl;

    initial begin
        reset = 1'b1;
        drive(OP_AND, 1'b0, COND_AL, 32'h0, 32'h0, 1'b0, 1'b0);
        chk("reset_flags", 32'(flags), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        next_edge();

        // Build up flags, then reset mid-cycle.
        drive(OP_ADD, 1'b1, COND_AL, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0);
        chk("adds_min_result", result, 32'h0);
        next_edge();
        chk("adds_min_flags", 32'(flags), 32'h7);
        #1 reset = 1'b1;
        #1;
        chk("async_reset_flags", 32'(flags), 32'h0);
        chk("reset_al_pass", 32'(cond_pass), 32'h1);
        cond = COND_EQ;
        #1;
        chk("reset_eq_pass", 32'(cond_pass), 32'h0);
        cond = COND_AL;
        next_edge();
        chk("reset_beats_we", 32'(flags), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        next_edge();
        chk("first_edge_after_reset", 32'(flags), 32'h7);

        // Signed overflow on ADD.
        drive(OP_ADD, 1'b1, COND_AL, 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0);
        chk("adds_ovf_result", result, 32'h8000_0000);
        chk("adds_ovf_rdw", 32'(rd_write), 32'h1);
        next_edge();
        chk("adds_ovf_flags", 32'(flags), 32'h9);

        drive(OP_MOV, 1'b1, COND_VS, 32'h0, 32'h1, 1'b0, 1'b0);
        chk("vs_pass", 32'(cond_pass), 32'h1);
        next_edge();
        chk("movs_keep_v", 32'(flags), 32'h1);

        drive(OP_MOV, 1'b1, COND_AL, 32'h1234_5678, 32'h0, 1'b1, 1'b0);
        chk("movs_zero_result", result, 32'h0);
        next_edge();
        chk("movs_zero_flags", 32'(flags), 32'h7);

        drive(OP_CMP, 1'b0, COND_AL, 32'h5, 32'h5, 1'b0, 1'b0);
        chk("cmp_rdw", 32'(rd_write), 32'h0);
        next_edge();
        chk("cmp_eq_flags", 32'(flags), 32'h6);

        drive(OP_ADD, 1'b1, COND_NE, 32'h1, 32'h1, 1'b0, 1'b0);
        chk("ne_pass", 32'(cond_pass), 32'h0);
        chk("ne_rdw", 32'(rd_write), 32'h0);
        chk("ne_result", result, 32'h2);
        next_edge();
        chk("ne_flags_held", 32'(flags), 32'h6);

        drive(OP_ADC, 1'b1, COND_AL, 32'hFFFF_FFFF, 32'h0, 1'b0, 1'b0);
        chk("adc_result", result, 32'h0);
        next_edge();
        chk("adc_flags", 32'(flags), 32'h6);

        drive(OP_SBC, 1'b1, COND_AL, 32'h0, 32'h0, 1'b0, 1'b0);
        chk("sbc_c1_result", result, 32'h0);
        next_edge();
        chk("sbc_c1_flags", 32'(flags), 32'h6);

        // All condition codes with flags = 0110.
        pass_tbl = 16'h66A5;
        for (int i = 0; i < 16; i++) begin
            drive(OP_AND, 1'b0, 4'(i), 32'h0, 32'h0, 1'b0, 1'b0);
            chk($sformatf("cond_0110_%0d", i), 32'(cond_pass), 32'(pass_tbl[i]));
        end

        // Non-compare opcodes, no flag write, C=1.
        ops[0]  = OP_AND; exps[0]  = 32'h00F0_0204;
        ops[1]  = OP_EOR; exps[1]  = 32'hFF00_1D3B;
        ops[2]  = OP_SUB; exps[2]  = 32'hE100_0325;
        ops[3]  = OP_RSB; exps[3]  = 32'h1EFF_FCDB;
        ops[4]  = OP_ADD; exps[4]  = 32'h00E0_2143;
        ops[5]  = OP_ADC; exps[5]  = 32'h00E0_2144;
        ops[6]  = OP_SBC; exps[6]  = 32'hE100_0325;
        ops[7]  = OP_RSC; exps[7]  = 32'h1EFF_FCDB;
        ops[8]  = OP_ORR; exps[8]  = 32'hFFF0_1F3F;
        ops[9]  = OP_MOV; exps[9]  = 32'h0FF0_0F0F;
        ops[10] = OP_BIC; exps[10] = 32'hF000_1030;
        ops[11] = OP_MVN; exps[11] = 32'hF00F_F0F0;
        for (int i = 0; i < 12; i++) begin
            drive(ops[i], 1'b0, COND_AL, 32'hF0F0_1234, 32'h0FF0_0F0F, 1'b0, 1'b0);
            chk($sformatf("op_%0d_result", i), result, exps[i]);
            chk($sformatf("op_%0d_rdw", i), 32'(rd_write), 32'h1);
        end
        next_edge();
        chk("no_s_flags_held", 32'(flags), 32'h6);

        drive(OP_CMP, 1'b0, COND_AL, 32'h0, 32'h1, 1'b0, 1'b0);
        chk("cmp_lt_result", result, 32'hFFFF_FFFF);
        next_edge();
        chk("cmp_lt_flags", 32'(flags), 32'h8);

        // All condition codes with flags = 1000.
        pass_tbl = 16'h6A9A;
        for (int i = 0; i < 16; i++) begin
            drive(OP_AND, 1'b0, 4'(i), 32'h0, 32'h0, 1'b0, 1'b0);
            chk($sformatf("cond_1000_%0d", i), 32'(cond_pass), 32'(pass_tbl[i]));
        end

        drive(OP_SBC, 1'b1, COND_AL, 32'h5, 32'h3, 1'b0, 1'b0);
        chk("sbc_c0_result", result, 32'h1);
        next_edge();
        chk("sbc_c0_flags", 32'(flags), 32'h2);

        // Stall freezes flags; combinational result remains valid.
        drive(OP_ADD, 1'b1, COND_AL, 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b1);
        chk("stall_result", result, 32'h0);
        for (int i = 0; i < 3; i++) begin
            next_edge();
            chk($sformatf("stall_flags_%0d", i), 32'(flags), 32'h2);
        end
        stall = 1'b0;
        next_edge();
        chk("unstall_flags", 32'(flags), 32'h6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
